// File: rtl/uart_tx.sv
// UART transmitter: start bit, n_bits data LSB first, optional even parity, n_stop stop bits.
// Define UART_TX_PARITY_EN to add the even-parity bit after the data bits.
module uart_tx #(
  parameter int unsigned clock_rate = 100000000,
  parameter int unsigned baud_rate  = 250000,
  parameter int unsigned n_bits     = 8,
  parameter int unsigned n_stop     = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [n_bits-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_tx,
  output logic              o_tx_busy,
  output logic              o_packet_done
);

  localparam int unsigned RateRatio = clock_rate / baud_rate;
  localparam int unsigned BaudW     = (RateRatio < 2) ? 1 : $clog2(RateRatio);
  localparam int unsigned BitW      = $clog2(n_bits) + 1;

  localparam logic [BaudW-1:0] BaudLast    = BaudW'(RateRatio - 1);
  localparam logic [BaudW-1:0] BaudPreLast = BaudW'(RateRatio - 2);
  localparam logic [BitW-1:0]  BitLast     = BitW'(n_bits - 1);
  localparam logic             StopLast    = 1'(n_stop - 1);

  if (RateRatio < 2) begin : g_bad_rate
    $error("uart_tx: clock_rate / baud_rate must be at least 2");
  end
  if (n_bits < 5 || n_bits > 16) begin : g_bad_bits
    $error("uart_tx: n_bits must be in 5..16");
  end
  if (n_stop != 1 && n_stop != 2) begin : g_bad_stop
    $error("uart_tx: n_stop must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e              r_state, w_state_next;
  logic [BaudW-1:0]    r_baud, w_baud_next;
  logic [BitW-1:0]     r_bit, w_bit_next;
  logic                r_stop, w_stop_next;
  logic [n_bits-1:0]   r_shift, w_shift_next;
  logic                r_tx, w_tx_next;
  logic                r_ready;
  logic                r_busy;
  logic                r_done, w_done_next;
  logic                w_tick;
`ifdef UART_TX_PARITY_EN
  logic                r_parity, w_parity_next;
`endif

  assign w_tick = (r_baud == BaudLast);

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = w_tick ? '0 : r_baud + 1'b1;
    w_bit_next   = r_bit;
    w_stop_next  = r_stop;
    w_shift_next = r_shift;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    unique case (r_state)
      StIdle: begin
        w_baud_next = '0;
        if (i_tx_valid && r_ready) begin
          w_shift_next = i_tx_data;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^i_tx_data;
`endif
          w_state_next = StStart;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_bit_next   = '0;
          w_state_next = StData;
        end
      end
      StData: begin
        if (w_tick) begin
          w_shift_next = {1'b0, r_shift[n_bits-1:1]};
          if (r_bit == BitLast) begin
            w_stop_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            w_state_next = StParity;
`else
            w_state_next = StStop;
`endif
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_tick) begin
          w_stop_next  = 1'b0;
          w_state_next = StStop;
        end
      end
`endif
      StStop: begin
        if (w_tick) begin
          if (r_stop == StopLast) begin
            w_state_next = StIdle;
          end else begin
            w_stop_next = r_stop + 1'b1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase

    // Line level follows the next state so tx changes on the same edge as the state.
    w_tx_next = 1'b1;
    case (w_state_next)
      StStart:  w_tx_next = 1'b0;
      StData:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      StParity: w_tx_next = w_parity_next;
`endif
      default:  w_tx_next = 1'b1;
    endcase

    // Raised one clock early so the registered pulse covers the final stop clock.
    w_done_next = (r_state == StStop) && (r_stop == StopLast) && (r_baud == BaudPreLast);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_baud   <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_stop   <= w_stop_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
      r_ready  <= (w_state_next == StIdle);
      r_busy   <= (w_state_next != StIdle);
      r_done   <= w_done_next;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  assign o_tx          = r_tx;
  assign o_tx_ready    = r_ready;
  assign o_tx_busy     = r_busy;
  assign o_packet_done = r_done;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's oversampling UART receiver. It accepts a parallel word over a valid/ready handshake and shifts it out on a single line at `baud_rate`. The frame is one start bit, `n_bits` data bits LSB first, an optional even-parity bit, then `n_stop` stop bits. It sits between a packet source (FIFO or controller) and the device pin, and uses the same clock/baud parameterisation as the receiver so the two pair directly.

## Interface
- `clock_rate`, default 100000000: system clock frequency in Hz.
- `baud_rate`, default 250000: line bit rate.
- `n_bits`, default 8: data bits per frame, range 5..16.
- `n_stop`, default 1: stop bits per frame, 1 or 2.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `tx_data`  in  n_bits: word to send; sampled only on handshake.
- `tx_valid`  in  1: source has a word.
- `tx_ready`  out  1: block accepts a word this cycle.
- `tx`  out  1: serial line; idle high; registered.
- `tx_busy`  out  1: frame in progress (state ≠ IDLE).
- `packet_done`  out  1: one-cycle pulse at the end of the final stop bit.

## Operation
- `rate_ratio = clock_rate / baud_rate` (integer division). Every bit lasts exactly `rate_ratio` clocks.
- Elaboration `$error` if `rate_ratio < 2`, `n_bits` is outside 5..16, or `n_stop` is not 1 or 2.
- Baud counter width is `$clog2(rate_ratio)`. It counts 0..rate_ratio-1, wraps, and raises `bit_tick` on count rate_ratio-1.
- Bit counter width is `$clog2(n_bits)+1`. Stop counter is 1 bit.
- States:
  - IDLE: `tx`=1, `tx_ready`=1. On `tx_valid && tx_ready`: capture `tx_data` into the shift register, clear the baud counter, go to START.
  - START: `tx`=0. On `bit_tick` go to DATA with bit counter 0.
  - DATA: `tx` = shift_reg[0]. On `bit_tick`: shift right; if bit counter = n_bits-1, go to PARITY (macro on) or STOP, else increment the bit counter.
  - PARITY: `tx` = XOR of the captured word (even parity). On `bit_tick` go to STOP.
  - STOP: `tx`=1. On `bit_tick`: if stop count = n_stop-1, pulse `packet_done` and go to IDLE; else increment the stop count.
- `tx_valid` and `tx_data` are ignored outside IDLE. `tx_data` changes mid-frame do not affect the frame.
- Deasserting `tx_valid` without a handshake is allowed and has no effect.

## Timing
- Reset values (asynchronous): state IDLE, `tx`=1, `tx_ready`=0, `tx_busy`=0, `packet_done`=0, all counters 0, shift register 0.
- `tx_ready` rises on the first clock edge after `rst` deasserts.
- `rst` asserted mid-frame: `tx` goes high immediately and the frame is abandoned. No `packet_done` is issued.
- Handshake at edge N:
  - `tx` falls at edge N+1.
  - `tx_ready` and `tx_busy` change at edge N+1.
  - `tx` is a registered output, so each bit is held for exactly `rate_ratio` clocks.
- Frame length from `tx` fall to IDLE: `(1 + n_bits + P + n_stop) * rate_ratio` clocks, where P = 1 with parity, else 0.
- `packet_done` is high in the last clock of the final stop bit. `tx_ready` is high on the following edge.
- Back-to-back: a source holding `tx_valid` high gets exactly one IDLE cycle between frames. The line therefore stays high for `n_stop*rate_ratio + 1` clocks between frames.
- No combinational path from inputs to outputs.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and one even-parity bit follows the data bits. Frame length includes P=1.
- `UART_TX_PARITY_EN` undefined: the PARITY state and parity logic are compiled out. DATA goes directly to STOP, P=0.
- The receiver must be configured to match.

## Test plan
All scenarios use `clock_rate`=8, `baud_rate`=1 (rate_ratio 8), `n_bits`=8, `n_stop`=1, parity off unless stated.
- Reset then idle: assert `rst` mid-run → `tx`=1 and `tx_ready`=0 at once. After release, `tx_ready`=1 on the next edge, `tx` stays 1 with `tx_valid` low.
- Single frame 0xA5 → `tx` pattern per 8-clock bit: 0,1,0,1,0,0,1,0,1,1. `packet_done` pulses at clock 80 after the handshake. `tx_busy` is high for 80 clocks.
- Parity 0xA5 and 0x01 with `UART_TX_PARITY_EN` → parity bit 0 for 0xA5 and 1 for 0x01. Frame is 88 clocks.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high → exactly 9 high clocks between frames. The second frame's data bits are all 1. `tx_data` changed mid-frame has no effect.
- `rst` during data bit 3 → `tx`=1 immediately, no `packet_done`. The next frame 0x3C after release transmits correctly.
- `n_stop`=2, frame 0x55 → stop interval is 16 high clocks. `packet_done` pulses at clock 88.
